// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared constants and FSM state type for the auto-baud configuration controller.
// Every other file in this block imports it.
package uart_autobaud_ctrl_pkg;

    localparam int unsigned DEF_CNT_W        = 32;
    localparam int unsigned DEF_DIV          = 130;
    localparam int unsigned DEF_TIMEOUT_CLKS = 65535;
    localparam int unsigned DEF_MIN_COUNT    = 128;
    localparam int unsigned DEF_SYNC_STAGES  = 2;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned SYNC_EDGES  = 5;
    // The measurement covers 8 bit times, so the division is cnt / (8 * OVERSAMPLE).
    localparam int unsigned ROUND_SHIFT = $clog2(8 * OVERSAMPLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Host-side configuration and status bundle between the config logic and the controller.
// The master side drives the commands; the slave side is the controller itself.
interface uart_autobaud_ctrl_if #(parameter int unsigned CNT_W = 32);

    logic             arm;
    logic             manual_load;
    logic [CNT_W-1:0] manual_div;
    logic [CNT_W-1:0] baud_division;
    logic             busy;
    logic             locked;
    logic             error;

    modport master (
        output arm, manual_load, manual_div,
        input  baud_division, busy, locked, error
    );

    modport slave (
        input  arm, manual_load, manual_div,
        output baud_division, busy, locked, error
    );

endinterface

// File: rtl/uart_autobaud_ctrl_rx_sync.sv
// Synchroniser for the asynchronous rx line, with single-cycle rise/fall pulses.
// Every edge sees the same latency, so widths measured between pulses are exact.
module uart_autobaud_ctrl_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              rx_prev;

    // The chain resets to 1 so an idle line never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain   <= '1;
            rx_prev <= 1'b1;
        end else begin
            chain   <= {chain[STAGES-2:0], rx};
            rx_prev <= chain[STAGES-1];
        end
    end

    assign rise = ~rx_prev & chain[STAGES-1];
    assign fall = rx_prev & ~chain[STAGES-1];

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Drives baud_division for uart_baud_rate, either from a manual load or from
// an auto-baud measurement of a 0x55 sync character on rx.
module uart_autobaud_ctrl
    import uart_autobaud_ctrl_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV  = DEF_DIV,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
    parameter int unsigned MIN_COUNT    = DEF_MIN_COUNT,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    uart_autobaud_ctrl_if.slave cfg
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] seg_cnt;
    logic [2:0]       edge_cnt;
    logic             rx_rise;
    logic             rx_fall;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] seg_next;
    logic [CNT_W:0]   rounded;
    logic [CNT_W:0]   quot;
    logic             seg_expired;

    uart_autobaud_ctrl_rx_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rise  (rx_rise),
        .fall  (rx_fall)
    );

    // Both counters saturate; a saturated count is treated as a timeout.
    assign cnt_next    = (&cnt) ? cnt : cnt + 1'b1;
    assign seg_next    = (&seg_cnt) ? seg_cnt : seg_cnt + 1'b1;
    assign seg_expired = (&seg_cnt) || (seg_cnt >= CNT_W'(TIMEOUT_CLKS - 1));
    assign rounded     = {1'b0, cnt} + ((CNT_W+1)'(1) << (ROUND_SHIFT - 1));
    assign quot        = rounded >> ROUND_SHIFT;

    // Manual load overrides everything, including a simultaneous arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            seg_cnt           <= '0;
            edge_cnt          <= '0;
            cfg.baud_division <= CNT_W'(DEFAULT_DIV);
            cfg.busy          <= 1'b0;
            cfg.locked        <= 1'b0;
            cfg.error         <= 1'b0;
        end else if (cfg.manual_load) begin
            state             <= ST_IDLE;
            cfg.baud_division <= cfg.manual_div;
            cfg.locked        <= |cfg.manual_div;
            cfg.error         <= 1'b0;
            cfg.busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg.arm) begin
                        state      <= ST_ARMED;
                        cfg.busy   <= 1'b1;
                        cfg.error  <= 1'b0;
                        cfg.locked <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (rx_fall) begin
                        cnt      <= '0;
                        seg_cnt  <= '0;
                        edge_cnt <= 3'd1;
                        state    <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    cnt     <= cnt_next;
                    seg_cnt <= (rx_rise || rx_fall) ? '0 : seg_next;
                    if (rx_fall) begin
                        edge_cnt <= edge_cnt + 3'd1;
                    end
                    if (rx_fall && edge_cnt == 3'(SYNC_EDGES - 1)) begin
                        state <= ST_DONE;
                    end else if ((&cnt) || (!(rx_rise || rx_fall) && seg_expired)) begin
                        state <= ST_FAIL;
                    end
                end
                ST_DONE: begin
                    if (cnt < CNT_W'(MIN_COUNT) || quot == '0) begin
                        state <= ST_FAIL;
                    end else begin
                        cfg.baud_division <= quot[CNT_W-1:0];
                        cfg.locked        <= 1'b1;
                        cfg.busy          <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    cfg.error  <= 1'b1;
                    cfg.locked <= 1'b0;
                    cfg.busy   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: directed and random sync characters
// compared against an arithmetic model of the expected division and status flags.
module tb_uart_autobaud_ctrl;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned TIMEOUT   = 4095;
    localparam int unsigned MIN_COUNT = 128;
    localparam int unsigned RESET_DIV = 130;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rx    = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] exp_div    = CNT_W'(RESET_DIV);
    logic             exp_locked = 1'b0;
    logic             exp_error  = 1'b0;

    uart_autobaud_ctrl_if #(.CNT_W(CNT_W)) cfg ();

    uart_autobaud_ctrl #(
        .DEFAULT_DIV  (RESET_DIV),
        .CNT_W        (CNT_W),
        .TIMEOUT_CLKS (TIMEOUT),
        .MIN_COUNT    (MIN_COUNT),
        .SYNC_STAGES  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .cfg   (cfg)
    );

    always #25 clk = ~clk;

    task automatic check_output(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        check_output({tag, ".div"},    cfg.baud_division, exp_div);
        check_output({tag, ".busy"},   CNT_W'(cfg.busy),   CNT_W'(exp_busy));
        check_output({tag, ".locked"}, CNT_W'(cfg.locked), CNT_W'(exp_locked));
        check_output({tag, ".error"},  CNT_W'(cfg.error),  CNT_W'(exp_error));
    endtask

    // A sync character spans 8 bit times between its first and fifth falling edge.
    function automatic void model_measure(input int unsigned bit_clks);
        longint unsigned total;
        total = 64'(8 * bit_clks);
        if (total < MIN_COUNT) begin
            exp_error  = 1'b1;
            exp_locked = 1'b0;
        end else begin
            exp_div    = CNT_W'((total + 64) / 128);
            exp_locked = 1'b1;
            exp_error  = 1'b0;
        end
    endfunction

    task automatic hold(input logic lvl, input int unsigned n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int unsigned bit_clks, input int first, input int last);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = first; i <= last; i++) hold(frame[i], bit_clks);
    endtask

    task automatic apply_stimulus(input logic do_arm, input logic do_load, input logic [CNT_W-1:0] div);
        cfg.arm         = do_arm;
        cfg.manual_load = do_load;
        cfg.manual_div  = div;
        @(negedge clk);
        cfg.arm         = 1'b0;
        cfg.manual_load = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max_clks);
        int unsigned n;
        n = 0;
        while (cfg.busy === 1'b1 && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        check_output("wait_idle", CNT_W'(cfg.busy), '0);
    endtask

    task automatic measure(input int unsigned bit_clks, input string tag);
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (5) @(negedge clk);
        send_frame(bit_clks, 0, 9);
        model_measure(bit_clks);
        wait_idle(50);
        check_all(tag, 1'b0);
    endtask

    initial begin
        cfg.arm         = 1'b0;
        cfg.manual_load = 1'b0;
        cfg.manual_div  = '0;

        #100 rst_n = 1'b0;
        #200 check_all("reset", 1'b0);
        #300 rst_n = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check_all("post_reset", 1'b0);

        // 9600 baud, busy checked mid-character
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (5) @(negedge clk);
        send_frame(2083, 0, 3);
        check_output("busy_9600", CNT_W'(cfg.busy), CNT_W'(1));
        send_frame(2083, 4, 9);
        model_measure(2083);
        wait_idle(50);
        check_all("baud_9600", 1'b0);

        measure(174, "baud_115200");

        // rx held low past the segment timeout
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (5) @(negedge clk);
        hold(1'b0, TIMEOUT - 100);
        check_output("timeout_busy", CNT_W'(cfg.busy), CNT_W'(1));
        check_output("timeout_early_err", CNT_W'(cfg.error), '0);
        repeat (1100) @(negedge clk);
        exp_error  = 1'b1;
        exp_locked = 1'b0;
        check_all("timeout", 1'b0);
        hold(1'b1, 20);

        // manual load aborts a running measurement
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (5) @(negedge clk);
        send_frame(2083, 0, 3);
        apply_stimulus(1'b0, 1'b1, CNT_W'(65));
        exp_div = 65; exp_locked = 1'b1; exp_error = 1'b0;
        check_all("manual_abort", 1'b0);
        send_frame(2083, 4, 7);
        hold(1'b1, 20);
        check_all("manual_abort_rest", 1'b0);

        // arm and manual load together: load wins, controller stays idle
        apply_stimulus(1'b1, 1'b1, CNT_W'(26));
        exp_div = 26; exp_locked = 1'b1; exp_error = 1'b0;
        check_all("arm_and_load", 1'b0);
        send_frame(100, 0, 9);
        check_all("arm_ignored", 1'b0);

        apply_stimulus(1'b0, 1'b1, '0);
        exp_div = 0; exp_locked = 1'b0;
        check_all("manual_zero", 1'b0);

        // arm while rx already low waits for a fresh falling edge
        hold(1'b0, 10);
        apply_stimulus(1'b1, 1'b0, '0);
        hold(1'b0, 30);
        hold(1'b1, 40);
        send_frame(90, 0, 9);
        model_measure(90);
        wait_idle(50);
        check_all("arm_rx_low", 1'b0);

        // a second arm mid-measurement must not restart it
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (5) @(negedge clk);
        send_frame(60, 0, 3);
        apply_stimulus(1'b1, 1'b0, '0);
        send_frame(60, 4, 9);
        model_measure(60);
        wait_idle(50);
        check_all("arm_while_busy", 1'b0);

        measure(15, "below_min_count");
        measure(16, "at_min_count");

        for (int i = 0; i < 8; i++) begin
            measure($urandom_range(10, 200), $sformatf("rand%0d", i));
        end

        // asynchronous reset in the middle of a measurement
        apply_stimulus(1'b1, 1'b0, '0);
        repeat (5) @(negedge clk);
        send_frame(200, 0, 2);
        rst_n = 1'b0;
        #1;
        exp_div = CNT_W'(RESET_DIV); exp_locked = 1'b0; exp_error = 1'b0;
        check_all("reset_mid", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_all("reset_mid_release", 1'b0);
        measure(77, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
